// File: rtl/stream_demux_pkg.sv
// Shared defaults, select encodings and the occupancy-width helper for the
// registered 1:2 stream demultiplexer.
package stream_demux_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 2;

  localparam logic OUT0 = 1'b0;
  localparam logic OUT1 = 1'b1;

  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/demux_fifo2.sv
// Small synchronous FIFO (DEPTH 2 or 4) with registered head, full flag and
// occupancy level; asynchronous active-high reset empties it.
module demux_fifo2
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic                      valid,
  output logic                      full,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int LW = level_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              push_ok, pop_ok;

  assign valid = (level_q != '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // Guards keep the FIFO safe even if a caller ignores full/valid.
  assign push_ok = push && !full;
  assign pop_ok  = pop && valid;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok && !pop_ok) begin
      level_d = level_q + LW'(1);
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/stream_demux_1to2.sv
// Registered 1:2 stream demux with an independent FIFO per output.
// Define ROUND_ROBIN_EN to ignore in_sel and alternate strictly between outputs.
module stream_demux_1to2
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_sel,
  output logic                      out0_valid,
  input  logic                      out0_ready,
  output logic [DATA_W-1:0]         out0_data,
  output logic                      out1_valid,
  input  logic                      out1_ready,
  output logic [DATA_W-1:0]         out1_data,
  output logic [level_w(DEPTH)-1:0] out0_level,
  output logic [level_w(DEPTH)-1:0] out1_level
);

  // Handshake: a beat moves on any edge where valid && ready are both high;
  // ready never depends combinationally on the matching valid.
  logic eff_sel;
  logic full0, full1;
  logic accept;
  logic push0, push1;
  logic pop0, pop1;

`ifdef ROUND_ROBIN_EN
  logic rr_ptr_q, rr_ptr_d;

  assign eff_sel = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = ~rr_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign eff_sel = in_sel;
`endif

  // Full flags are registered, so a full buffer refuses a beat even while popping.
  assign in_ready = (eff_sel == OUT1) ? !full1 : !full0;
  assign accept   = in_valid && in_ready;
  assign push0    = accept && (eff_sel == OUT0);
  assign push1    = accept && (eff_sel == OUT1);
  assign pop0     = out0_valid && out0_ready;
  assign pop1     = out1_valid && out1_ready;

  demux_fifo2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push0),
    .pop   (pop0),
    .din   (in_data),
    .dout  (out0_data),
    .valid (out0_valid),
    .full  (full0),
    .level (out0_level)
  );

  demux_fifo2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .pop   (pop1),
    .din   (in_data),
    .dout  (out1_data),
    .valid (out1_valid),
    .full  (full1),
    .level (out1_level)
  );

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Bench for stream_demux_1to2: directed scenarios plus random traffic, checked
// against per-output expected queues with a DEPTH-bounded occupancy model.
module tb_stream_demux_1to2;

  localparam int W     = 8;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_sel = 1'b0;
  logic         out0_valid, out1_valid;
  logic         out0_ready = 1'b0;
  logic         out1_ready = 1'b0;
  logic [W-1:0] out0_data, out1_data;
  logic [1:0]   out0_level, out1_level;

  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];
  logic         rr_m = 1'b0;
  int           checks = 0;
  int           failures = 0;

  stream_demux_1to2 #(.DATA_W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out0_level (out0_level),
    .out1_level (out1_level)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // driver tasks
  task automatic cycle(input logic v, input logic s, input logic [W-1:0] d,
                       input logic r0, input logic r1);
    @(posedge clk);
    #1;
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  // scoreboard monitor: compares every cycle, then advances the model
  always @(negedge clk) begin
    logic eff;
    logic exp_rdy;
    if (rst) begin
      exp0_q.delete();
      exp1_q.delete();
      rr_m = 1'b0;
    end else begin
      chk("out0_valid", int'(out0_valid), int'(exp0_q.size() != 0));
      chk("out1_valid", int'(out1_valid), int'(exp1_q.size() != 0));
      chk("out0_level", int'(out0_level), exp0_q.size());
      chk("out1_level", int'(out1_level), exp1_q.size());
      if (exp0_q.size() != 0) chk("out0_data", int'(out0_data), int'(exp0_q[0]));
      if (exp1_q.size() != 0) chk("out1_data", int'(out1_data), int'(exp1_q[0]));
`ifdef ROUND_ROBIN_EN
      eff = rr_m;
`else
      eff = in_sel;
`endif
      exp_rdy = eff ? (exp1_q.size() < DEPTH) : (exp0_q.size() < DEPTH);
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      if (out0_ready && exp0_q.size() != 0) void'(exp0_q.pop_front());
      if (out1_ready && exp1_q.size() != 0) void'(exp1_q.pop_front());
      if (in_valid && exp_rdy) begin
        if (eff) exp1_q.push_back(in_data);
        else     exp0_q.push_back(in_data);
        rr_m = ~rr_m;
      end
    end
  end

  initial begin
    #2;
    chk("rst_out0_valid", int'(out0_valid), 0);
    chk("rst_out1_valid", int'(out1_valid), 0);
    chk("rst_out0_data", int'(out0_data), 0);
    chk("rst_out1_data", int'(out1_data), 0);
    chk("rst_levels", int'({out0_level, out1_level}), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    #4 rst = 1'b0;

    // single beat to out0
    cycle(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    idle(3);

    // out0 fills at two, third refused until a pop frees a slot
    cycle(1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'h02, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'h03, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'h03, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 8'h03, 1'b1, 1'b1);
    idle(4);

    // out0 full and stalled while out1 keeps accepting
    cycle(1'b1, 1'b0, 8'h20, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'h21, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    idle(4);

    // simultaneous push and pop on out1 at level 1
    cycle(1'b1, 1'b1, 8'h30, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 8'h31, 1'b1, 1'b1);
    idle(4);

    // random traffic with phased back-pressure
    for (int i = 0; i < 1500; i++) begin
      int bias = (i / 250) % 3;
      cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), W'($urandom),
            $urandom_range(0, 3) > bias, $urandom_range(0, 3) >= bias);
    end
    idle(6);

    // fill both outputs, then reset between edges
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'(i), 8'hC0 + W'(i), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_out0_valid", int'(out0_valid), 0);
    chk("arst_out1_valid", int'(out1_valid), 0);
    chk("arst_levels", int'({out0_level, out1_level}), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    #3 rst = 1'b0;
    cycle(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
